// File: rtl/affine2_pe_cfg_if.sv
// Link between adjacent affine-gap PEs: query load, target stream, cell values
// and running max travel together from PE k to PE k+1.
interface affine2_pe_cfg_if #(
    parameter int CALC_W = 16,
    parameter int BP_W   = 2,
    parameter int ADDR_W = 10
);
    logic        [BP_W-1:0]   s;
    logic                     s_load;
    logic        [BP_W-1:0]   t;
    logic                     valid;
    logic                     last;
    logic signed [CALC_W-1:0] h;
    logic signed [CALC_W-1:0] f;
    logic signed [CALC_W-1:0] f_hat;
    logic signed [CALC_W-1:0] mx;
    logic        [ADDR_W-1:0] mx_row;
    logic        [ADDR_W-1:0] mx_col;
    logic        [ADDR_W-1:0] row;

    modport master (output s, s_load, t, valid, last, h, f, f_hat, mx, mx_row, mx_col, row);
    modport slave  (input  s, s_load, t, valid, last, h, f, f_hat, mx, mx_row, mx_col, row);
endinterface

// File: rtl/affine2_pe_cfg.sv
// Systolic PE for two-piece affine-gap alignment: holds one query base and scores
// one DP cell per valid target base, with saturating score arithmetic.
module affine2_pe_cfg #(
    parameter int CALC_W   = 16,
    parameter int BP_W     = 2,
    parameter int ADDR_W   = 10,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 4,
    parameter int Q        = 4,
    parameter int E        = 2,
    parameter int QH       = 24,
    parameter int EH       = 1
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              local_i,
    affine2_pe_cfg_if.slave   up,
    affine2_pe_cfg_if.master  dn,
    output logic [4:0]        dir_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic              busy_out
);
    typedef logic signed [CALC_W-1:0] sc_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} st_t;

    localparam sc_t MAX_V   = {1'b0, {(CALC_W-1){1'b1}}};
    localparam sc_t MIN_V   = {1'b1, {(CALC_W-1){1'b0}}};
    // -2^(W-1) + 2^(W-3): leaves headroom so gap chains never hit the rail early
    localparam sc_t NEG_INF = {3'b101, {(CALC_W-3){1'b0}}};
    localparam sc_t C_E     = sc_t'(E);
    localparam sc_t C_QE    = sc_t'(Q + E);
    localparam sc_t C_EH    = sc_t'(EH);
    localparam sc_t C_QHEH  = sc_t'(QH + EH);
    localparam sc_t C_MA    = sc_t'(MATCH);
    localparam sc_t C_MM    = sc_t'(-MISMATCH);

    function automatic sc_t sat_add(sc_t a, sc_t b);
        logic [CALC_W:0] s;
        s = {a[CALC_W-1], a} + {b[CALC_W-1], b};
        if (s[CALC_W] != s[CALC_W-1]) return s[CALC_W] ? MIN_V : MAX_V;
        return sc_t'(s[CALC_W-1:0]);
    endfunction

    function automatic sc_t sat_sub(sc_t a, sc_t b);
        logic [CALC_W:0] s;
        s = {a[CALC_W-1], a} - {b[CALC_W-1], b};
        if (s[CALC_W] != s[CALC_W-1]) return s[CALC_W] ? MIN_V : MAX_V;
        return sc_t'(s[CALC_W-1:0]);
    endfunction

    function automatic sc_t smax(sc_t a, sc_t b);
        return (a > b) ? a : b;
    endfunction

    st_t               state_q, state_d;
    logic              local_q;
    logic [ADDR_W-1:0] col_q;
    sc_t               e_q, eh_q, hl_q, hd_q;
    logic [BP_W-1:0]   s_q, t_q;
    logic              sl_q, vld_q, last_q;
    sc_t               h_q, f_q, fh_q, mx_q;
    logic [ADDR_W-1:0] mxr_q, mxc_q, row_q, wr_q;
    logic [4:0]        dir_q;

    logic              start, lcl;
    logic [ADDR_W-1:0] c, row_inc;
    sc_t               e_prev, eh_prev, hl, hd, sc;
    sc_t               e_ext, e_opn, e_new, eh_ext, eh_opn, eh_new;
    sc_t               f_ext, f_opn, f_new, fh_ext, fh_opn, fh_new;
    sc_t               d, best, h_new;
    logic [4:0]        dir_new;

    // A valid base outside RUN opens a new target, including straight out of DRAIN.
    always_comb begin
        start   = up.valid && (state_q != RUN);
        lcl     = start ? local_i : local_q;
        c       = start ? '0      : col_q;
        e_prev  = start ? NEG_INF : e_q;
        eh_prev = start ? NEG_INF : eh_q;
        hl      = start ? '0      : hl_q;
        hd      = start ? '0      : hd_q;
        row_inc = up.row + 1'b1;
        sc      = (s_q == up.t) ? C_MA : C_MM;

        e_ext   = sat_sub(e_prev, C_E);
        e_opn   = sat_sub(hl, C_QE);
        e_new   = smax(e_ext, e_opn);
        eh_ext  = sat_sub(eh_prev, C_EH);
        eh_opn  = sat_sub(hl, C_QHEH);
        eh_new  = smax(eh_ext, eh_opn);
        f_ext   = sat_sub(up.f, C_E);
        f_opn   = sat_sub(up.h, C_QE);
        f_new   = smax(f_ext, f_opn);
        fh_ext  = sat_sub(up.f_hat, C_EH);
        fh_opn  = sat_sub(up.h, C_QHEH);
        fh_new  = smax(fh_ext, fh_opn);
        d       = sat_add(hd, sc);

        best    = smax(smax(smax(d, e_new), smax(f_new, eh_new)), fh_new);
        h_new   = (lcl && best < 0) ? '0 : best;

        dir_new = {f_ext >= f_opn, e_ext >= e_opn, 3'b000};
        if      (d      == h_new) dir_new[2:0] = 3'b000;
        else if (e_new  == h_new) dir_new[2:0] = 3'b001;
        else if (f_new  == h_new) dir_new[2:0] = 3'b010;
        else if (eh_new == h_new) dir_new[2:0] = 3'b101;
        else if (fh_new == h_new) dir_new[2:0] = 3'b110;
        else                      dir_new[2:0] = 3'b011;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DRAIN: if (up.valid) state_d = up.last ? DRAIN : RUN;
                         else          state_d = IDLE;
            RUN:         if (up.valid && up.last) state_d = DRAIN;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            local_q <= 1'b0;
            col_q   <= '0;
            e_q     <= NEG_INF;
            eh_q    <= NEG_INF;
            hl_q    <= NEG_INF;
            hd_q    <= '0;
            s_q     <= '0;
            sl_q    <= 1'b0;
            t_q     <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            h_q     <= '0;
            f_q     <= '0;
            fh_q    <= '0;
            mx_q    <= '0;
            mxr_q   <= '0;
            mxc_q   <= '0;
            row_q   <= '0;
            dir_q   <= '0;
            wr_q    <= '0;
        end else if (en_i) begin
            state_q <= state_d;
            if (up.s_load) s_q <= up.s;
            sl_q    <= up.s_load;
            t_q     <= up.t;
            vld_q   <= up.valid;
            last_q  <= up.last;
            row_q   <= row_inc;
            if (up.valid) begin
                col_q   <= c + 1'b1;
                local_q <= lcl;
                e_q     <= e_new;
                eh_q    <= eh_new;
                hl_q    <= h_new;
                hd_q    <= up.h;
                h_q     <= h_new;
                f_q     <= f_new;
                fh_q    <= fh_new;
                dir_q   <= dir_new;
                wr_q    <= c;
            end else begin
                h_q     <= '0;
                f_q     <= '0;
                fh_q    <= '0;
                dir_q   <= '0;
            end
            // Ties keep the upstream max so the earliest row wins.
            if (up.valid && h_new > up.mx) begin
                mx_q  <= h_new;
                mxr_q <= row_inc;
                mxc_q <= c;
            end else begin
                mx_q  <= up.mx;
                mxr_q <= up.mx_row;
                mxc_q <= up.mx_col;
            end
        end
    end

    assign dn.s        = s_q;
    assign dn.s_load   = sl_q;
    assign dn.t        = t_q;
    assign dn.valid    = vld_q;
    assign dn.last     = last_q;
    assign dn.h        = h_q;
    assign dn.f        = f_q;
    assign dn.f_hat    = fh_q;
    assign dn.mx       = mx_q;
    assign dn.mx_row   = mxr_q;
    assign dn.mx_col   = mxc_q;
    assign dn.row      = row_q;
    assign dir_out     = dir_q;
    assign wr_addr_out = wr_q;
endmodule
